// File: rtl/m_gate_arbiter_pkg.sv
// Shared types for the gate arbiter: opcodes and FSM state encodings.
package m_gate_arbiter_pkg;

    // Gate opcodes, all bitwise over the operand width
    typedef enum logic [1:0] {
        OP_NOT = 2'b00,
        OP_AND = 2'b01,
        OP_OR  = 2'b10,
        OP_XOR = 2'b11
    } op_t;

    // Arbiter FSM states; the fourth encoding is illegal and recovers to IDLE
    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_EXEC = 2'b01,
        S_RESP = 2'b10
    } state_t;

    localparam int OP_W = 2;

endpackage

// File: rtl/m_gate_arbiter_if.sv
// Requester-side bus of the gate arbiter.
//
// Handshake: requester i raises req_valid[i] with req_op/req_a/req_b slice i and
// holds them stable until req_ready[i] is seen high in a cycle; that cycle is the
// accept. Dropping valid before ready is legal and commits nothing. Exactly two
// cycles after the accept, resp_valid[i] pulses for one cycle with the result on
// resp_data, which then holds until the next response.
interface m_gate_arbiter_if #(
    parameter int N_REQ = 4,
    parameter int WIDTH = 8
);
    import m_gate_arbiter_pkg::*;

    logic [N_REQ-1:0]       req_valid;
    logic [2*N_REQ-1:0]     req_op;
    logic [WIDTH*N_REQ-1:0] req_a;
    logic [WIDTH*N_REQ-1:0] req_b;
    logic [N_REQ-1:0]       req_ready;
    logic [N_REQ-1:0]       resp_valid;
    logic [WIDTH-1:0]       resp_data;
    logic                   busy;
    state_t                 fsm_state;

    modport master (
        output req_valid, req_op, req_a, req_b,
        input  req_ready, resp_valid, resp_data, busy, fsm_state
    );

    modport slave (
        input  req_valid, req_op, req_a, req_b,
        output req_ready, resp_valid, resp_data, busy, fsm_state
    );

endinterface

// File: rtl/m_gate_arbiter_gate_unit.sv
// Purely combinational shared logic-gate unit; the result register lives in the arbiter.
module m_gate_unit
    import m_gate_arbiter_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  op_t              op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] y
);

    // Select the bitwise function named by the opcode
    always_comb begin
        y = '0;
        case (op)
            OP_NOT:  y = ~a;
            OP_AND:  y = a & b;
            OP_OR:   y = a | b;
            OP_XOR:  y = a ^ b;
            default: y = '0;
        endcase
    end

endmodule

// File: rtl/m_gate_arbiter.sv
// Round-robin scheduler sharing one registered gate unit among N_REQ requesters.
// Each accepted request takes three cycles: accept (IDLE), compute (EXEC), respond (RESP).
module m_gate_arbiter
    import m_gate_arbiter_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    m_gate_arbiter_if.slave  bus
);

    localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    state_t             state;
    logic [IDX_W-1:0]   last_grant;
    logic [IDX_W-1:0]   win_q;
    op_t                op_q;
    logic [WIDTH-1:0]   a_q;
    logic [WIDTH-1:0]   b_q;
    logic [N_REQ-1:0]   resp_valid_q;
    logic [WIDTH-1:0]   resp_data_q;
    logic [WIDTH-1:0]   gate_y;

    logic               pick_found;
    logic [IDX_W-1:0]   pick_idx;
    int                 cand;
    op_t                sel_op;
    logic [WIDTH-1:0]   sel_a;
    logic [WIDTH-1:0]   sel_b;

    // Round-robin search: first valid requester after last_grant, wrapping at N_REQ
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        cand       = 0;
        for (int k = 1; k <= N_REQ; k++) begin
            cand = (int'(last_grant) + k) % N_REQ;
            if (!pick_found && bus.req_valid[IDX_W'(cand)]) begin
                pick_found = 1'b1;
                pick_idx   = IDX_W'(cand);
            end
        end
    end

    // Route the winner's opcode and operands toward the capture registers
    always_comb begin
        sel_op = OP_NOT;
        sel_a  = '0;
        sel_b  = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (pick_idx == IDX_W'(i)) begin
                sel_op = op_t'(bus.req_op[OP_W*i +: OP_W]);
                sel_a  = bus.req_a[WIDTH*i +: WIDTH];
                sel_b  = bus.req_b[WIDTH*i +: WIDTH];
            end
        end
    end

    m_gate_unit #(.WIDTH(WIDTH)) u_gate (
        .op (op_q),
        .a  (a_q),
        .b  (b_q),
        .y  (gate_y)
    );

    // Main FSM: capture winner in IDLE, register gate result in EXEC, strobe response in RESP
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= S_IDLE;
            last_grant   <= IDX_W'(N_REQ - 1);
            win_q        <= '0;
            op_q         <= OP_NOT;
            a_q          <= '0;
            b_q          <= '0;
            resp_valid_q <= '0;
            resp_data_q  <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    resp_valid_q <= '0;
                    if (pick_found) begin
                        op_q  <= sel_op;
                        a_q   <= sel_a;
                        b_q   <= sel_b;
                        win_q <= pick_idx;
                        state <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    resp_data_q  <= gate_y;
                    resp_valid_q <= N_REQ'(1) << win_q;
                    state        <= S_RESP;
                end
                S_RESP: begin
                    resp_valid_q <= '0;
                    last_grant   <= win_q;
                    state        <= S_IDLE;
                end
                default: begin
                    resp_valid_q <= '0;
                    state        <= S_IDLE;
                end
            endcase
        end
    end

    // Accept strobe depends only on state and the valid vector, so it is one-hot or zero
    assign bus.req_ready  = (state == S_IDLE && pick_found) ? (N_REQ'(1) << pick_idx) : '0;
    assign bus.resp_valid = resp_valid_q;
    assign bus.resp_data  = resp_data_q;
    assign bus.busy       = (state != S_IDLE);
    assign bus.fsm_state  = state;

endmodule

// File: tb/tb_m_gate_arbiter.sv
// Bench for m_gate_arbiter: directed scenarios plus random traffic against a
// round-robin reference model, with responses checked from an expected queue.
module tb_m_gate_arbiter;
    import m_gate_arbiter_pkg::*;

    localparam int N  = 4;
    localparam int W  = 8;
    localparam int EW = 32 + 4 + W;   // {due cycle, requester, data}

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    m_gate_arbiter_if #(.N_REQ(N), .WIDTH(W)) bus ();

    m_gate_arbiter #(.N_REQ(N), .WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- bookkeeping ----------------
    int n_vec = 0;
    int n_err = 0;
    logic [EW-1:0] exp_q[$];
    int grant_log[$];
    int grant_cyc[$];

    // Reference model state
    int         m_busy;
    int         m_last;
    logic [W-1:0] m_data;

    logic [N-1:0]  chk_er;
    int            chk_g;
    logic [EW-1:0] mon_e;
    logic [N-1:0]  seen;
    int            n_two;
    int            exp_order[6] = '{0, 1, 2, 3, 0, 1};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [W-1:0] ref_op(input logic [1:0] op, input logic [W-1:0] a,
                                             input logic [W-1:0] b);
        case (op)
            2'd0:    return ~a;
            2'd1:    return a & b;
            2'd2:    return a | b;
            default: return a ^ b;
        endcase
    endfunction

    // Winner = valid requester at the smallest circular distance after the last winner
    function automatic int pick(input logic [N-1:0] v, input int last);
        int best  = -1;
        int bestd = N;
        for (int c = 0; c < N; c++) begin
            if (v[c] && ((c - last - 1 + N) % N) < bestd) begin
                bestd = (c - last - 1 + N) % N;
                best  = c;
            end
        end
        return best;
    endfunction

    task automatic model_reset();
        m_busy = 0;
        m_last = N - 1;
        m_data = '0;
        exp_q.delete();
    endtask

    // ---------------- reference model / stimulus-side scoreboard ----------------
    always @(negedge clk) begin
        if (!rst) begin
            chk_er = '0;
            check("busy", 32'(bus.busy), 32'(m_busy > 0));
            if (m_busy > 0) begin
                m_busy--;
            end else begin
                chk_g = pick(bus.req_valid, m_last);
                if (chk_g >= 0) begin
                    chk_er[chk_g] = 1'b1;
                    exp_q.push_back({32'(cyc + 2), 4'(chk_g),
                                     ref_op(bus.req_op[2*chk_g +: 2], bus.req_a[W*chk_g +: W],
                                            bus.req_b[W*chk_g +: W])});
                    m_last = chk_g;
                    m_busy = 2;
                    grant_log.push_back(chk_g);
                    grant_cyc.push_back(cyc);
                end
            end
            check("req_ready", 32'(bus.req_ready), 32'(chk_er));
        end
    end

    // ---------------- response monitor ----------------
    always @(negedge clk) begin
        if (!rst) begin
            if (bus.resp_valid != '0) begin
                if (exp_q.size() == 0) begin
                    check("resp_unexpected", 32'(bus.resp_valid), 32'(0));
                end else begin
                    mon_e = exp_q.pop_front();
                    check("resp_cycle", 32'(cyc), mon_e[EW-1 -: 32]);
                    check("resp_valid", 32'(bus.resp_valid), 32'(1) << mon_e[W +: 4]);
                    check("resp_data", 32'(bus.resp_data), 32'(mon_e[W-1:0]));
                    m_data = mon_e[W-1:0];
                end
            end else if (exp_q.size() > 0 && int'(exp_q[0][EW-1 -: 32]) <= cyc) begin
                mon_e = exp_q.pop_front();
                check("resp_missing", 32'(bus.resp_valid), 32'(1) << mon_e[W +: 4]);
            end
            check("resp_data_hold", 32'(bus.resp_data), 32'(m_data));
        end
    end

    // ---------------- driver tasks ----------------
    task automatic clear_inputs();
        bus.req_valid = '0;
        bus.req_op    = '0;
        bus.req_a     = '0;
        bus.req_b     = '0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_busy"}, 32'(bus.busy), 32'(0));
        check({tag, "_ready"}, 32'(bus.req_ready), 32'(0));
        check({tag, "_resp_valid"}, 32'(bus.resp_valid), 32'(0));
        check({tag, "_resp_data"}, 32'(bus.resp_data), 32'(0));
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b1;
        clear_inputs();
        model_reset();
        #1;
        check_reset_outputs("reset");
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    // Raise a request, hold it until ready is seen, then drop valid (returns in EXEC)
    task automatic issue(input int idx, input logic [1:0] op, input logic [W-1:0] a,
                         input logic [W-1:0] b);
        bit got = 1'b0;
        @(posedge clk); #1;
        bus.req_valid[idx]       = 1'b1;
        bus.req_op[2*idx +: 2]   = op;
        bus.req_a[W*idx +: W]    = a;
        bus.req_b[W*idx +: W]    = b;
        for (int k = 0; k < 30 && !got; k++) begin
            @(negedge clk);
            if (bus.req_ready[idx]) got = 1'b1;
        end
        if (!got) check("issue_timeout", 32'(got), 32'(1));
        @(posedge clk); #1;
        bus.req_valid[idx] = 1'b0;
    endtask

    // ---------------- main sequence ----------------
    initial begin
        clear_inputs();
        model_reset();
        do_reset();

        // Single NOT from requester 0
        issue(0, 2'b00, 8'h5A, 8'h00);
        repeat (3) @(posedge clk);
        #1;
        check("not_result", 32'(bus.resp_data), 32'h0000_00A5);

        // AND / OR / XOR back-to-back on requester 1
        grant_cyc.delete();
        issue(1, 2'b01, 8'hF0, 8'h3C);
        issue(1, 2'b10, 8'hF0, 8'h3C);
        issue(1, 2'b11, 8'hF0, 8'h3C);
        repeat (3) @(posedge clk);
        #1;
        check("ops_count", 32'(grant_cyc.size()), 32'(3));
        if (grant_cyc.size() == 3) begin
            check("ops_spacing0", 32'(grant_cyc[1] - grant_cyc[0]), 32'(3));
            check("ops_spacing1", 32'(grant_cyc[2] - grant_cyc[1]), 32'(3));
        end
        check("xor_result", 32'(bus.resp_data), 32'h0000_00CC);

        // Full contention from a fresh reset
        do_reset();
        grant_log.delete();
        for (int i = 0; i < N; i++) begin
            bus.req_op[2*i +: 2] = 2'($urandom_range(0, 3));
            bus.req_a[W*i +: W]  = W'($urandom);
            bus.req_b[W*i +: W]  = W'($urandom);
        end
        bus.req_valid = '1;
        repeat (18) @(posedge clk);
        #1;
        bus.req_valid = '0;
        repeat (3) @(posedge clk);
        check("contention_count", 32'(grant_log.size()), 32'(6));
        for (int i = 0; i < 6 && i < grant_log.size(); i++)
            check("contention_order", 32'(grant_log[i]), 32'(exp_order[i]));

        // Rotation: after requester 2 is served, 3 beats 0
        issue(2, 2'b01, 8'hAA, 8'h0F);
        grant_log.delete();
        fork
            issue(3, 2'b10, 8'h11, 8'h22);
            issue(0, 2'b11, 8'h33, 8'h44);
        join
        repeat (3) @(posedge clk);
        check("rotation_count", 32'(grant_log.size()), 32'(2));
        if (grant_log.size() == 2) begin
            check("rotation_first", 32'(grant_log[0]), 32'(3));
            check("rotation_second", 32'(grant_log[1]), 32'(0));
        end

        // Withdrawal: requester 2 raises valid in EXEC and drops it in RESP
        grant_log.delete();
        issue(0, 2'b01, 8'h0F, 8'hFF);
        bus.req_valid[2]     = 1'b1;
        bus.req_op[4 +: 2]   = 2'b00;
        bus.req_a[W*2 +: W]  = 8'h77;
        @(posedge clk); #1;
        bus.req_valid[2] = 1'b0;
        repeat (4) @(posedge clk);
        n_two = 0;
        foreach (grant_log[i]) if (grant_log[i] == 2) n_two++;
        check("withdraw_grants2", 32'(n_two), 32'(0));
        check("withdraw_count", 32'(grant_log.size()), 32'(1));

        // Asynchronous reset in EXEC
        issue(1, 2'b10, 8'h81, 8'h18);
        #2;
        rst = 1'b1;
        #1;
        check_reset_outputs("rst_exec");
        clear_inputs();
        model_reset();
        @(posedge clk); #1;
        rst = 1'b0;
        grant_log.delete();
        fork
            issue(0, 2'b00, 8'h0F, 8'h00);
            issue(2, 2'b01, 8'hFF, 8'h55);
        join
        repeat (3) @(posedge clk);
        check("post_reset_first", 32'(grant_log.size() > 0 ? grant_log[0] : -1), 32'(0));

        // Random traffic with random withdrawals
        @(posedge clk); #1;
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            seen = bus.req_ready;
            @(posedge clk); #1;
            for (int i = 0; i < N; i++) begin
                if (seen[i]) begin
                    bus.req_valid[i] = 1'b0;
                end else if (bus.req_valid[i]) begin
                    if ($urandom_range(0, 15) == 0) bus.req_valid[i] = 1'b0;
                end else if ($urandom_range(0, 2) == 0) begin
                    bus.req_valid[i]      = 1'b1;
                    bus.req_op[2*i +: 2]  = 2'($urandom_range(0, 3));
                    bus.req_a[W*i +: W]   = W'($urandom);
                    bus.req_b[W*i +: W]   = W'($urandom);
                end
            end
        end
        bus.req_valid = '0;
        repeat (6) @(posedge clk);
        #1;
        check("queue_drained", 32'(exp_q.size()), 32'(0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    // Watchdog so the run always ends
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, %0d vectors, %0d miscompares",
                 n_vec, n_err);
        $fatal(1);
    end

endmodule

// File: doc/m_gate_arbiter.md
Name: m_gate_arbiter

Overview:
- Round-robin scheduler sharing one registered logic-gate unit (NOT/AND/OR/XOR) among N_REQ requesters.
- Each requester presents an opcode and operands through a valid/ready handshake and receives a one-cycle response strobe carrying the result.
- Sits above the gate-primitive library (m_not and siblings) as the controller that sequences the shared gate resource.

Parameters:
- N_REQ, 4, number of requesters (2..8)
- WIDTH, 8, operand/result width in bits

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- req_valid  in  N_REQ  per-requester request valid
- req_op  in  2*N_REQ  per-requester opcode; requester i uses bits [2i+1:2i]
- req_a  in  WIDTH*N_REQ  operand A; requester i uses slice i
- req_b  in  WIDTH*N_REQ  operand B; requester i uses slice i
- req_ready  out  N_REQ  one-hot accept strobe
- resp_valid  out  N_REQ  one-hot response strobe
- resp_data  out  WIDTH  result, shared by all requesters
- busy  out  1  high when the FSM is not in IDLE

Behaviour:
- Opcodes:
  - 00: NOT a (b ignored)
  - 01: a AND b
  - 10: a OR b
  - 11: a XOR b
  - All bitwise over WIDTH bits.
- Reset (asynchronous, rst=1):
  - state=IDLE; last_grant=N_REQ-1, so requester 0 has first priority.
  - Operand/op/winner registers cleared.
  - resp_valid=0, resp_data=0, busy=0, req_ready=0.
- FSM states:
  - IDLE: if any req_valid, pick a winner by round-robin search starting at last_grant+1 (mod N_REQ). req_ready[winner]=1 combinationally in this cycle. Latch op, a, b and the winner index on the clock edge; go to EXEC. If no req_valid, stay in IDLE with req_ready=0.
  - EXEC: the m_gate_unit result is registered into the result register; go to RESP.
  - RESP: resp_valid[winner]=1 for exactly this cycle; resp_data=result; last_grant<=winner; go to IDLE.
- req_ready is a combinational function of state and req_valid only. It is 0 outside IDLE and has at most one bit set.
- Latency and throughput:
  - Request accepted at cycle T (ready=1), response at cycle T+2.
  - One operation per 3 cycles; no pipelining, no queue.
- resp_data holds its value until the next RESP cycle. resp_valid is 0 in all non-RESP cycles.
- Handshake rules:
  - A requester holds valid, op and operands stable until its ready is seen.
  - Deasserting valid before ready is legal: nothing is committed and the requester is skipped.
  - Changes to other requesters' inputs during EXEC/RESP have no effect.
- Simultaneous requests: only one grant per IDLE cycle. The previous winner has the lowest priority on the next search.
- Re-request: a requester granted in RESP may re-request in the following IDLE cycle. It wins only if no other requester is valid.
- busy = (state != IDLE).
- Reset mid-operation (EXEC or RESP): the operation is aborted with no resp_valid, and all state returns to reset values.
- Illegal state encodings recover to IDLE.

Decomposition:
- Shared header m_defs.vh holds:
  - opcode constants OP_NOT=2'b00, OP_AND=2'b01, OP_OR=2'b10, OP_XOR=2'b11;
  - FSM state encodings S_IDLE, S_EXEC, S_RESP.
- Sub-module m_gate_unit: purely combinational, ports op/a/b/y. It contains no registers; the result register lives in m_gate_arbiter.
- Round-robin pick is a function or always block inside m_gate_arbiter, not a separate module.

Test Plan:
- Single NOT: after reset, req_valid=0001, op=00, a0=8'h5A at cycle T → req_ready=0001 at T; resp_valid=0001 at T+2 with resp_data=8'hA5; busy high during T+1..T+2.
- All ops on requester 1: a=8'hF0, b=8'h3C, ops 01/10/11 issued back-to-back → resp_data 8'h30, 8'hFC, 8'hCC, each 2 cycles after its accept; one accept per 3 cycles.
- Full contention: req_valid=1111 held throughout → grant order 0,1,2,3,0,1. Each ready is one-hot, never two in one cycle.
- Rotation check: after requester 2 is served, present req_valid=1001 → requester 3 is granted before requester 0.
- Valid withdrawal: requester 2 raises valid during EXEC of another op, then drops it before IDLE → requester 2 never sees ready or resp_valid.
- Reset in EXEC: assert rst asynchronously mid-cycle → busy=0, resp_valid stays 0, resp_data=0. Next request from requester 0 wins (last_grant=N_REQ-1).
